ps2_pad_ctrl: RTL and testbench

- Host-side controller for a DualShock-style PS2 gamepad.
- Drives ATT/CLK/CMD, polls the pad with a 9-byte frame at a fixed rate and decodes the reply into ID, button word and four stick bytes.
- Sits directly upstream of the UART reporting stage. Its outputs connect 1:1 to that stage's PS2 inputs: data-valid, key, RX, RY, LX, LY, ID.

---
 rtl/ps2_pad_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_pad_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ps2_pad_ctrl.sv
// Host-side PS2 gamepad poller: bit-bangs ATT/CLK/CMD, shifts in a 9-byte reply
// at a fixed frame rate and publishes ID, buttons and stick bytes on good frames.
module ps2_pad_ctrl #(
  parameter int CLK_FRE     = 50,
  parameter int PS2_CLK_KHZ = 250,
  parameter int BYTE_GAP_US = 16,
  parameter int POLL_FRE    = 100
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_dat,
  output logic       o_ps2_cmd,
  output logic       o_ps2_att,
  output logic       o_ps2_clk,
  output logic       o_PS2_data_valid,
  output logic [15:0] o_PS2_key,
  output logic [7:0] o_PS2_RX,
  output logic [7:0] o_PS2_RY,
  output logic [7:0] o_PS2_LX,
  output logic [7:0] o_PS2_LY,
  output logic [7:0] o_PS2_ID
);

  localparam int HALF_CNT = CLK_FRE * 1000 / (2 * PS2_CLK_KHZ);
  localparam int GAP_CNT  = CLK_FRE * BYTE_GAP_US;
  localparam int POLL_CNT = CLK_FRE * 1000000 / POLL_FRE;
  localparam int CNT_MAX  = (HALF_CNT > GAP_CNT) ? HALF_CNT : GAP_CNT;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int PW       = $clog2(POLL_CNT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CNT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_BIT_LO, S_BIT_HI, S_GAP, S_DONE} state_t;

  function automatic logic [7:0] cmd_of(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_of = 8'h01;
      4'd1:    cmd_of = 8'h42;
      default: cmd_of = 8'h00;
    endcase
  endfunction

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  poll_q;
  logic [2:0]     bit_cnt_q;
  logic [3:0]     byte_cnt_q;
  logic [7:0]     rx_byte_q;
  logic [8:1][7:0] b_q;
  logic           dat_s1_q, dat_s2_q;
  logic           att_q, clk_q, cmd_q, valid_q;
  logic [15:0]    key_q;
  logic [7:0]     rx_q, ry_q, lx_q, ly_q, id_q;

  logic           poll_wrap_d, good_d;
  logic [7:0]     cur_cmd_d, nxt_cmd_d;

  always_comb begin
    poll_wrap_d = (poll_q == POLL_LAST);
    cur_cmd_d   = cmd_of(byte_cnt_q);
    nxt_cmd_d   = cmd_of(byte_cnt_q + 4'd1);
    good_d      = (b_q[2] == 8'h5A) && ((b_q[1] == 8'h41) || (b_q[1] == 8'h73));
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      poll_q   <= POLL_LAST;
    end else begin
      dat_s1_q <= i_ps2_dat;
      dat_s2_q <= dat_s1_q;
      poll_q   <= poll_wrap_d ? '0 : poll_q + PW'(1);
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_byte_q  <= 8'h00;
      b_q        <= '0;
      att_q      <= 1'b1;
      clk_q      <= 1'b1;
      cmd_q      <= 1'b1;
      valid_q    <= 1'b0;
      key_q      <= 16'h0000;
      rx_q       <= 8'd128;
      ry_q       <= 8'd128;
      lx_q       <= 8'd128;
      ly_q       <= 8'd128;
      id_q       <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          att_q      <= 1'b1;
          clk_q      <= 1'b1;
          cmd_q      <= 1'b1;
          cnt_q      <= '0;
          bit_cnt_q  <= '0;
          byte_cnt_q <= '0;
          if (poll_wrap_d) begin
            att_q   <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            cmd_q   <= cur_cmd_d[bit_cnt_q];
            state_q <= S_BIT_LO;
          end
        end
        S_BIT_LO: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            clk_q   <= 1'b1;
            state_q <= S_BIT_HI;
          end
        end
        S_BIT_HI: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == HALF_LAST) begin
            cnt_q                <= '0;
            rx_byte_q[bit_cnt_q] <= dat_s2_q;
            if (bit_cnt_q == 3'd7) begin
              cmd_q   <= 1'b1;
              state_q <= S_GAP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              clk_q     <= 1'b0;
              cmd_q     <= cur_cmd_d[bit_cnt_q + 3'd1];
              state_q   <= S_BIT_LO;
            end
          end
        end
        S_GAP: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            // Byte 0 of the reply is filler and never inspected.
            if (byte_cnt_q != 4'd0) b_q[byte_cnt_q] <= rx_byte_q;
            if (byte_cnt_q == 4'd8) begin
              state_q <= S_DONE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 4'd1;
              bit_cnt_q  <= '0;
              clk_q      <= 1'b0;
              cmd_q      <= nxt_cmd_d[0];
              state_q    <= S_BIT_LO;
            end
          end
        end
        S_DONE: begin
          att_q   <= 1'b1;
          state_q <= S_IDLE;
          if (good_d) begin
            valid_q <= 1'b1;
            id_q    <= b_q[1];
            key_q   <= {~b_q[4], ~b_q[3]};
            // Digital mode carries no analog data; park sticks at centre.
            if (b_q[1] == 8'h73) begin
              rx_q <= b_q[5];
              ry_q <= b_q[6];
              lx_q <= b_q[7];
              ly_q <= b_q[8];
            end else begin
              rx_q <= 8'd128;
              ry_q <= 8'd128;
              lx_q <= 8'd128;
              ly_q <= 8'd128;
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ps2_cmd        = cmd_q;
  assign o_ps2_att        = att_q;
  assign o_ps2_clk        = clk_q;
  assign o_PS2_data_valid = valid_q;
  assign o_PS2_key        = key_q;
  assign o_PS2_RX         = rx_q;
  assign o_PS2_RY         = ry_q;
  assign o_PS2_LX         = lx_q;
  assign o_PS2_LY         = ly_q;
  assign o_PS2_ID         = id_q;

endmodule

// File: tb/tb_ps2_pad_ctrl.sv
// Directed bench for ps2_pad_ctrl with a behavioural pad on ATT/CLK/CMD/DAT.
module tb_ps2_pad_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dat = 1'b1;
  logic        cmd, att, pclk, valid;
  logic [15:0] key;
  logic [7:0]  rx, ry, lx, ly, id;

  ps2_pad_ctrl #(.CLK_FRE(1), .PS2_CLK_KHZ(250), .BYTE_GAP_US(4), .POLL_FRE(2500)) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_ps2_dat(dat),
    .o_ps2_cmd(cmd), .o_ps2_att(att), .o_ps2_clk(pclk),
    .o_PS2_data_valid(valid), .o_PS2_key(key),
    .o_PS2_RX(rx), .o_PS2_RY(ry), .o_PS2_LX(lx), .o_PS2_LY(ly), .o_PS2_ID(id)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [7:0] reply  [0:8];
  logic [7:0] cmd_rx [0:8];
  int fall_cnt = 0, cyc = 0, fall_at = 0, period = 0;
  logic prev_pclk = 1'b1, prev_att = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_reply(input logic [71:0] v);
    for (int i = 0; i < 9; i++) reply[i] = v[71-8*i -: 8];
  endtask

  // Pad model: drives DAT after each CLK fall, captures CMD at each CLK rise.
  always @(negedge clk) begin
    cyc++;
    if (prev_att && !att) begin
      period   = cyc - fall_at;
      fall_at  = cyc;
      fall_cnt = 0;
    end
    if (att) dat = 1'b1;
    else if (prev_pclk && !pclk) begin
      if (fall_cnt < 72) dat = reply[fall_cnt/8][fall_cnt%8];
      fall_cnt++;
    end else if (!prev_pclk && pclk && fall_cnt > 0 && fall_cnt <= 72)
      cmd_rx[(fall_cnt-1)/8][(fall_cnt-1)%8] = cmd;
    prev_pclk = pclk;
    prev_att  = att;
  end

  int          lowcyc, n;
  logic        pre_v;
  logic [15:0] pre_k;

  task automatic wait_frame(output int lc, output logic pv, output logic [15:0] pk);
    int w;
    w = 0;
    pv = valid;
    pk = key;
    while (att && w < 1000) begin @(negedge clk); w++; end
    if (att) chk("att_fall_timeout", {31'd0, att}, 32'd0);
    lc = 0;
    while (!att && lc < 1000) begin
      pv = valid;
      pk = key;
      @(negedge clk);
      lc++;
    end
    if (!att) chk("att_rise_timeout", {31'd0, att}, 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] k,
                         input logic [7:0] i, input logic [31:0] sticks);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, "_key"}, {16'd0, key}, {16'd0, k});
    chk({tag, "_id"}, {24'd0, id}, {24'd0, i});
    chk({tag, "_sticks"}, {rx, ry, lx, ly}, sticks);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) cmd_rx[i] = 8'h00;
    set_reply(72'hFF_73_5A_FE_7F_00_FF_80_40);
    repeat (3) @(negedge clk);
    chk("rst_pins", {29'd0, att, pclk, cmd}, 32'd7);
    chk_out("rst", 1'b0, 16'h0000, 8'h00, 32'h80808080);

    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (att && n < 10);
    chk("att_fall_latency", n, 1);
    wait_frame(lowcyc, pre_v, pre_k);
    chk("frame_len", lowcyc, 327);
    chk("clk_falls", fall_cnt, 72);
    for (int i = 0; i < 9; i++)
      chk($sformatf("cmd_byte%0d", i), {24'd0, cmd_rx[i]}, (i == 0) ? 32'h01 : (i == 1) ? 32'h42 : 32'h00);
    chk("analog_pre_valid", {31'd0, pre_v}, 32'd0);
    chk("analog_pre_key", {16'd0, pre_k}, 32'd0);
    chk_out("analog", 1'b1, 16'h8001, 8'h73, 32'h00FF8040);

    set_reply(72'hFF_73_00_FE_7F_11_22_33_44);
    wait_frame(lowcyc, pre_v, pre_k);
    chk("bad_pre_valid", {31'd0, pre_v}, 32'd1);
    chk_out("bad", 1'b0, 16'h8001, 8'h73, 32'h00FF8040);

    set_reply(72'hFF_41_5A_F0_FF_12_34_56_78);
    wait_frame(lowcyc, pre_v, pre_k);
    chk("digital_pre_valid", {31'd0, pre_v}, 32'd0);
    chk_out("digital", 1'b1, 16'h000F, 8'h41, 32'h80808080);

    set_reply({72{1'b1}});
    wait_frame(lowcyc, pre_v, pre_k);
    chk_out("nopad1", 1'b0, 16'h000F, 8'h41, 32'h80808080);
    wait_frame(lowcyc, pre_v, pre_k);
    chk("nopad_period", period, 400);
    chk_out("nopad2", 1'b0, 16'h000F, 8'h41, 32'h80808080);

    set_reply(72'hFF_73_5A_FE_7F_00_FF_80_40);
    n = 0;
    while (att && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (fall_cnt < 35 && n < 1000) begin @(negedge clk); n++; end
    if (fall_cnt < 35) chk("byte4_timeout", fall_cnt, 35);
    chk("midrst_pre_att", {31'd0, att}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_pins", {29'd0, att, pclk, cmd}, 32'd7);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_key", {16'd0, key}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 9; i++) cmd_rx[i] = 8'hEE;
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (att && n < 10);
    chk("midrst_fall_latency", n, 1);
    wait_frame(lowcyc, pre_v, pre_k);
    chk("midrst_frame_len", lowcyc, 327);
    chk("midrst_cmd0", {24'd0, cmd_rx[0]}, 32'h01);
    chk("midrst_cmd1", {24'd0, cmd_rx[1]}, 32'h42);
    chk_out("midrst_frame", 1'b1, 16'h8001, 8'h73, 32'h00FF8040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
